me_fre: RTL and testbench

Measured-frequency block: counts rising edges of the DDS output (`sig_in`, a comparator square wave) over a fixed gate window, then converts the count to four BCD digits for the left display group. It is the measurement counterpart of the theoretical-frequency path. The theoretical path derives frequency from the switch value; this block measures what the DDS actually produces, so the two readings can be compared side by side. Output goes to the left-display driver, whose `number[15:0]` input has the same format as the theoretical path's `bcd`.

---
 rtl/fre_pkg.sv | 41 ++++
 rtl/bin_to_bcd_seq.sv | 76 +++++++
 rtl/fre_conv_chk.sv | 24 ++
 rtl/me_fre.sv | 157 +++++++++++++++
 tb/tb_me_fre.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/fre_pkg.sv
// ---------------------------------------------------------------------------
// fre_pkg
// Constants, types and helpers shared by the measured-frequency and
// theoretical-frequency display paths.
//   BCD_W / BIN_W : display word widths (4 BCD digits, 14-bit binary)
//   MAX_DISP      : largest value the four-digit display can show
//   conv_state_e  : states of the sequential binary-to-BCD converter
//   dd_step()     : one double-dabble iteration (add-3 adjust, then shift)
// ---------------------------------------------------------------------------
package fre_pkg;

    localparam int BCD_W = 16;
    localparam int BIN_W = 14;
    // Double-dabble work register: BCD digits above the binary operand.
    localparam int DD_W  = BCD_W + BIN_W;

    localparam logic [BIN_W-1:0] MAX_DISP  = 14'd9999;
    localparam logic [BIN_W-1:0] EDGE_MAX  = 14'd16383;
    // Iteration counter runs 0..BIN_W-1.
    localparam logic [3:0]       ITER_LAST = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    // One double-dabble iteration: every BCD digit >= 5 gets +3 so that the
    // following left shift carries correctly into the next decimal digit.
    function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] v);
        logic [DD_W-1:0] a;
        a = v;
        for (int n = 0; n < 4; n++) begin
            if (a[BIN_W + 4*n +: 4] >= 4'd5) begin
                a[BIN_W + 4*n +: 4] = a[BIN_W + 4*n +: 4] + 4'd3;
            end
        end
        return {a[DD_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential double-dabble converter, 14 iterations per conversion.
//   signal : clock, rising edge
//   rst_n  : asynchronous active-low reset (returns to IDLE, drops result)
//   start  : load bin and begin converting (honoured only in IDLE)
//   bin    : binary operand, must be <= 9999
//   bcd    : four BCD digits, valid while done is high and held afterwards
//   done   : one-cycle pulse, the cycle after the last iteration
// Latency: start in cycle T -> done high in cycle T+15.
// ---------------------------------------------------------------------------
module bin_to_bcd_seq
    import fre_pkg::*;
(
    input  logic             signal,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    conv_state_e     state_q;
    logic [DD_W-1:0] sh_q;
    logic [3:0]      iter_q;
    logic            done_q;

    // Converter FSM: IDLE waits for start, SHIFT iterates, DONE flags result.
    always_ff @(posedge signal or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sh_q    <= {DD_W{1'b0}};
            iter_q  <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sh_q    <= {{BCD_W{1'b0}}, bin};
                        iter_q  <= 4'd0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sh_q   <= dd_step(sh_q);
                    iter_q <= iter_q + 4'd1;
                    if (iter_q == ITER_LAST) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // After 14 shifts the binary operand has moved fully into the digit field.
    assign bcd  = sh_q[DD_W-1:BIN_W];
    assign done = done_q;

    fre_conv_chk u_chk (
        .signal (signal),
        .rst_n  (rst_n),
        .start  (start),
        .busy   (state_q != ST_IDLE)
    );

endmodule

// File: rtl/fre_conv_chk.sv
// ---------------------------------------------------------------------------
// fre_conv_chk
// Property checker for the sequential BCD converter.
//   signal : clock
//   rst_n  : asynchronous active-low reset
//   start  : conversion request (gate_end of the measuring path)
//   busy   : converter is not in IDLE
// A start while busy means the gate window is shorter than a conversion.
// ---------------------------------------------------------------------------
module fre_conv_chk (
    input  logic signal,
    input  logic rst_n,
    input  logic start,
    input  logic busy
);

    property p_start_only_idle;
        @(posedge signal) disable iff (!rst_n) start |-> !busy;
    endproperty

    a_start_only_idle: assert property (p_start_only_idle)
        else $error("fre_conv_chk: start arrived while conversion busy");

endmodule

// File: rtl/me_fre.sv
// ---------------------------------------------------------------------------
// me_fre
// Measured frequency: counts rising edges of sig_in over a free-running gate
// of GATE_CYCLES clocks and presents the count as four BCD digits.
//   CLK_HZ      : system clock frequency in Hz
//   GATE_CYCLES : gate length in clocks (default 1 s), minimum 32
//   signal      : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   sig_in      : measured square wave, asynchronous to signal
//   bcd         : measured value, [15:12] thousands .. [3:0] units
//   bin         : measured value in binary, clamped to 9999
//   ovf         : last window counted more than 9999 edges
//   valid       : one-cycle pulse when bcd/bin/ovf update
// gate_end in cycle T -> outputs update at the end of T+15, valid in T+16.
// ---------------------------------------------------------------------------
module me_fre
    import fre_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned GATE_CYCLES = CLK_HZ
) (
    input  logic             signal,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [BCD_W-1:0] bcd,
    output logic [BIN_W-1:0] bin,
    output logic             ovf,
    output logic             valid
);

    localparam int              GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [GW-1:0]   GATE_ONE  = GW'(1);

    // Input conditioning
    logic             sync1_q, sync2_q, prev_q, edge_q;
    // Gate and edge counters
    logic             run_q;
    logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
    logic [BIN_W-1:0] edge_cnt_q, edge_cnt_d;
    // Window result and converter interface
    logic             gate_end_s;
    logic [BIN_W:0]   sum_s;
    logic [BIN_W-1:0] snap_s, clamp_s;
    logic             ovf_s;
    logic [BIN_W-1:0] hold_bin_q;
    logic             hold_ovf_q;
    logic [BCD_W-1:0] conv_bcd_s;
    logic             conv_done_s;
    // Output registers
    logic [BCD_W-1:0] bcd_q;
    logic [BIN_W-1:0] bin_q;
    logic             ovf_q;
    logic             valid_q;

    // Synchronize sig_in and register the rising-edge pulse (3 cycles latency).
    always_ff @(posedge signal or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= sync2_q & ~prev_q;
        end
    end

    // Window bookkeeping: gate end, saturating snapshot, clamp and next counts.
    always_comb begin
        gate_end_s = run_q && (gate_cnt_q == GATE_LAST);
        // The edge of the gate_end cycle still belongs to the closing window.
        sum_s = {1'b0, edge_cnt_q} + {{BIN_W{1'b0}}, edge_q};
        if (sum_s > {1'b0, EDGE_MAX}) begin
            snap_s = EDGE_MAX;
        end else begin
            snap_s = sum_s[BIN_W-1:0];
        end
        if (snap_s > MAX_DISP) begin
            clamp_s = MAX_DISP;
            ovf_s   = 1'b1;
        end else begin
            clamp_s = snap_s;
            ovf_s   = 1'b0;
        end
        if (gate_end_s) begin
            edge_cnt_d = {BIN_W{1'b0}};
        end else begin
            edge_cnt_d = snap_s;
        end
        // run_q holds the gate at 0 until the first edge after reset release,
        // so that edge starts gate count 0.
        if (!run_q || gate_end_s) begin
            gate_cnt_d = {GW{1'b0}};
        end else begin
            gate_cnt_d = gate_cnt_q + GATE_ONE;
        end
    end

    // Free-running gate counter and never-pausing edge counter.
    always_ff @(posedge signal or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            gate_cnt_q <= {GW{1'b0}};
            edge_cnt_q <= {BIN_W{1'b0}};
        end else begin
            run_q      <= 1'b1;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    // Keep the clamped count and overflow of the closing window for the output.
    always_ff @(posedge signal or negedge rst_n) begin
        if (!rst_n) begin
            hold_bin_q <= {BIN_W{1'b0}};
            hold_ovf_q <= 1'b0;
        end else if (gate_end_s) begin
            hold_bin_q <= clamp_s;
            hold_ovf_q <= ovf_s;
        end
    end

    bin_to_bcd_seq u_conv (
        .signal (signal),
        .rst_n  (rst_n),
        .start  (gate_end_s),
        .bin    (clamp_s),
        .bcd    (conv_bcd_s),
        .done   (conv_done_s)
    );

    // Output registers: update together when the converter finishes.
    always_ff @(posedge signal or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q   <= {BCD_W{1'b0}};
            bin_q   <= {BIN_W{1'b0}};
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= conv_done_s;
            if (conv_done_s) begin
                bcd_q <= conv_bcd_s;
                bin_q <= hold_bin_q;
                ovf_q <= hold_ovf_q;
            end
        end
    end

    assign bcd   = bcd_q;
    assign bin   = bin_q;
    assign ovf   = ovf_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_me_fre.sv
// ---------------------------------------------------------------------------
// tb_me_fre
// Seven me_fre instances share one clock. Instance 0 (gate 100) gets hand-
// placed edges around gate_end and a reset in the middle of a conversion.
// Instances 1..6 see free-running square waves; their expected counts come
// from where each rising edge lands after the 3-cycle input pipeline.
// Expected results are queued per instance and popped on each valid pulse.
// ---------------------------------------------------------------------------
module tb_me_fre;

    localparam int NI    = 7;
    localparam int K_END = 50020;
    localparam int GATE_TAB [NI] = '{100, 1000, 30000, 50000, 10000, 10000, 10000};
    localparam int PER_TAB  [NI] = '{0,   10,   4,     4,     20,    7,     3};

    typedef struct {
        int bin;
        int bcd;
        int ovf;
        int k;
    } exp_t;

    logic          clk;
    logic          rst_a, rst_f;
    logic          sig_a;
    logic [NI-1:0] sig_f;
    logic [15:0]   bcd_w   [NI];
    logic [13:0]   bin_w   [NI];
    logic          ovf_w   [NI];
    logic          valid_w [NI];

    exp_t sb_q [NI][$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   k_a   = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        me_fre #(
            .CLK_HZ      (100_000_000),
            .GATE_CYCLES (GATE_TAB[g])
        ) u_dut (
            .signal (clk),
            .rst_n  ((g == 0) ? rst_a : rst_f),
            .sig_in ((g == 0) ? sig_a : sig_f[g]),
            .bcd    (bcd_w[g]),
            .bin    (bin_w[g]),
            .ovf    (ovf_w[g]),
            .valid  (valid_w[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int to_bcd(input int v);
        return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
               (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    // A rise driven in cycle k (k % P == 0) shows as an edge in cycle k+3.
    function automatic int pulses_upto(input int x, input int p);
        return (x < 3) ? 0 : ((x - 3) / p + 1);
    endfunction

    task automatic push_exp(input int i, input int cnt, input int k);
        exp_t e;
        e.ovf = (cnt > 9999) ? 1 : 0;
        e.bin = (cnt > 9999) ? 9999 : cnt;
        e.bcd = to_bcd(e.bin);
        e.k   = k;
        sb_q[i].push_back(e);
    endtask

    // Advance instance 0 to cycle t (counted from its reset release), 1 after the edge.
    task automatic step_to(input int t);
        while (k_a < t) begin
            @(posedge clk);
            k_a++;
        end
        #1;
    endtask

    // Scoreboard: pop and compare on every valid pulse of every instance.
    initial begin : mon
        int   km [NI];
        exp_t e;
        for (int i = 0; i < NI; i++) km[i] = 0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < NI; i++) begin
                if (((i == 0) ? rst_a : rst_f) == 1'b1) km[i]++;
                else km[i] = 0;
            end
            #1;
            for (int i = 0; i < NI; i++) begin
                if (valid_w[i] === 1'b1) begin
                    if (sb_q[i].size() == 0) begin
                        chk($sformatf("u%0d_unexpected_valid_k%0d", i, km[i]), int'(valid_w[i]), 0);
                    end else begin
                        e = sb_q[i].pop_front();
                        chk($sformatf("u%0d_valid_cycle", i), km[i], e.k);
                        chk($sformatf("u%0d_bin_k%0d", i, e.k), int'(bin_w[i]), e.bin);
                        chk($sformatf("u%0d_bcd_k%0d", i, e.k), int'(bcd_w[i]), e.bcd);
                        chk($sformatf("u%0d_ovf_k%0d", i, e.k), int'(ovf_w[i]), e.ovf);
                    end
                end
            end
        end
    end

    initial begin : main
        rst_a = 1'b0;
        rst_f = 1'b0;
        sig_a = 1'b0;
        sig_f = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d_rst_bcd", i), int'(bcd_w[i]), 0);
            chk($sformatf("u%0d_rst_bin", i), int'(bin_w[i]), 0);
            chk($sformatf("u%0d_rst_ovf", i), int'(ovf_w[i]), 0);
            chk($sformatf("u%0d_rst_valid", i), int'(valid_w[i]), 0);
        end

        // Release all instances together; cycle 0 levels of the free waves.
        rst_a = 1'b1;
        rst_f = 1'b1;
        k_a   = 0;
        for (int i = 1; i < NI; i++) sig_f[i] = 1'b1;

        for (int i = 1; i < NI; i++) begin
            for (int n = 1; n * GATE_TAB[i] + 16 <= K_END; n++) begin
                push_exp(i, pulses_upto(n * GATE_TAB[i], PER_TAB[i]) -
                            pulses_upto((n - 1) * GATE_TAB[i], PER_TAB[i]),
                         n * GATE_TAB[i] + 16);
            end
        end

        fork
            begin : free_drive
                int kf;
                kf = 0;
                while (kf < K_END) begin
                    @(posedge clk);
                    kf++;
                    #1;
                    for (int i = 1; i < NI; i++) begin
                        sig_f[i] = ((kf % PER_TAB[i]) < (PER_TAB[i] / 2));
                    end
                end
            end
            begin : inst0_seq
                // Gate 100: windows end at 100, 200, 300, 400, 500.
                push_exp(0, 0, 116);          // no input: zero reading
                push_exp(0, 1, 216);          // edge in the gate_end cycle
                push_exp(0, 0, 316);
                push_exp(0, 1, 416);          // edge one cycle after gate_end
                step_to(197); sig_a = 1'b1;   // edge lands in cycle 200
                step_to(199); sig_a = 1'b0;
                step_to(298); sig_a = 1'b1;   // edge lands in cycle 301
                step_to(300); sig_a = 1'b0;
                // Window 5 gets three edges, but its conversion is reset away.
                step_to(420); sig_a = 1'b1;
                step_to(425); sig_a = 1'b0;
                step_to(440); sig_a = 1'b1;
                step_to(445); sig_a = 1'b0;
                step_to(460); sig_a = 1'b1;
                step_to(465); sig_a = 1'b0;
                step_to(508);
                #1 rst_a = 1'b0;
                #1;
                chk("u0_midconv_rst_bcd", int'(bcd_w[0]), 0);
                chk("u0_midconv_rst_bin", int'(bin_w[0]), 0);
                chk("u0_midconv_rst_ovf", int'(ovf_w[0]), 0);
                chk("u0_midconv_rst_valid", int'(valid_w[0]), 0);
                repeat (3) @(posedge clk);
                @(negedge clk);
                rst_a = 1'b1;
                k_a   = 0;
                push_exp(0, 3, 116);          // first valid G+16 after release
                step_to(10); sig_a = 1'b1;
                step_to(15); sig_a = 1'b0;
                step_to(20); sig_a = 1'b1;
                step_to(25); sig_a = 1'b0;
                step_to(30); sig_a = 1'b1;
                step_to(35); sig_a = 1'b0;
                step_to(130);
                rst_a = 1'b0;                 // park instance 0 in reset
            end
        join

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d_pending_results", i), sb_q[i].size(), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
